// File: rtl/conv_agu_gen_if.sv
// Tap-tuple bus of the convolution address generator, together with its index-buffer read port.
interface conv_agu_gen_if #(
    parameter int ADDR_W = 8,
    parameter int IDX_W  = 4,
    parameter int BATCH  = 4
);
    localparam int SEL_W = $clog2(BATCH);

    logic [ADDR_W-1:0]  idx_rd_addr;
    logic [2*IDX_W-1:0] idx;
    logic               out_valid;
    logic [ADDR_W-1:0]  dbuf_addr;
    logic               dbuf_mask;
    logic [1:0]         dbuf_mux;
    logic [ADDR_W-1:0]  pbuf_addr;
    logic [SEL_W-1:0]   pbuf_sel;
    logic [ADDR_W-1:0]  abuf_addr;
    logic [BATCH-1:0]   abuf_acc_en;
    logic               abuf_acc_new;
    logic               mac_new_acc;

    modport master (
        output idx_rd_addr, out_valid, dbuf_addr, dbuf_mask, dbuf_mux, pbuf_addr,
               pbuf_sel, abuf_addr, abuf_acc_en, abuf_acc_new, mac_new_acc,
        input  idx
    );

    modport slave (
        input  idx_rd_addr, out_valid, dbuf_addr, dbuf_mask, dbuf_mux, pbuf_addr,
               pbuf_sel, abuf_addr, abuf_acc_en, abuf_acc_new, mac_new_acc,
        output idx
    );
endinterface

// File: rtl/conv_agu_gen.sv
// Convolution address generator: walks ker_x/ker_y/pix/chan and emits one buffer-address tuple
// per tap through a four-stage pipeline; the index buffer is read in the second stage.
//   state   | meaning
//   S_IDLE  | waiting for start, outputs quiet
//   S_RUN   | issuing one tap per unstalled cycle
//   S_DRAIN | final tap issued, waiting for it to leave the pipeline
module conv_agu_gen #(
    parameter int ADDR_W   = 8,
    parameter int IDX_W    = 4,
    parameter int BATCH    = 4,
    parameter int KER_MAX  = 5,
    parameter int GRP_ID_Y = 0,
    parameter int GRP_ID_X = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stall,
    output logic       busy,
    output logic       done,
    input  logic [1:0] conf_mode,
    input  logic [2:0] conf_ker,
    input  logic       conf_stride,
    input  logic [5:0] conf_row_cnt,
    input  logic [7:0] conf_trip_cnt,
    input  logic       conf_is_new,
    input  logic       conf_pad_u,
    input  logic       conf_pad_l,
    input  logic [5:0] conf_lim_r,
    input  logic [5:0] conf_lim_d,
    conv_agu_gen_if.master bus
);
    localparam int SEL_W = $clog2(BATCH);
    localparam int LIN_W = ADDR_W + SEL_W;
    localparam int KW    = $clog2(KER_MAX + 1);
    localparam int DW    = IDX_W + 4;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2} state_t;

    typedef struct packed {
        logic              valid;
        logic              fin;
        logic              mask;
        logic [1:0]        mux;
        logic [3:0]        pe_bits;
        logic [ADDR_W-1:0] dbuf_addr;
        logic [ADDR_W-1:0] pbuf_addr;
        logic [SEL_W-1:0]  pbuf_sel;
        logic [ADDR_W-1:0] abuf_addr;
        logic              acc_en;
        logic              acc_new;
        logic              mac_new;
    } tap_t;

    state_t            state_q, state_d;
    logic              mode_q, stride_q, new_q, padu_q, padl_q;
    logic [KW-1:0]     ker_q;
    logic [5:0]        row_q, limr_q, limd_q;
    logic [7:0]        trip_q;
    logic [KW-1:0]     kx_q, kx_d, ky_q, ky_d;
    logic [5:0]        pix_q, pix_d;
    logic [7:0]        chan_q, chan_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              issue, accept, final_tap;
    logic              last_kx, last_ky, last_pix, last_chan;
    logic [7:0]        wx, wy, pex, pey;
    logic [LIN_W-1:0]  lin;
    tap_t              tap_d, st1_d;
    tap_t              pipe_q [4];
    logic              unused_bits;

    assign issue  = (state_q == S_RUN) && !stall;
    assign accept = (state_q == S_IDLE) && start;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (issue && final_tap) state_d = S_DRAIN;
            S_DRAIN: if (!stall && pipe_q[3].valid && pipe_q[3].fin) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != S_IDLE);
    end

    always_comb begin
        last_kx   = (kx_q == ker_q - KW'(1));
        last_ky   = (ky_q == ker_q - KW'(1));
        last_pix  = (pix_q == row_q);
        last_chan = (chan_q == trip_q);
        final_tap = last_kx && last_ky && last_pix && last_chan;
        kx_d      = last_kx ? '0 : kx_q + KW'(1);
        ky_d      = last_kx ? (last_ky ? '0 : ky_q + KW'(1)) : ky_q;
        pix_d     = (last_kx && last_ky) ? (last_pix ? '0 : pix_q + 6'd1) : pix_q;
        chan_d    = chan_q;
        rd_addr_d = rd_addr_q;
        if (last_kx && last_ky && last_pix) begin
            chan_d = last_chan ? '0 : chan_q + 8'd1;
            if (!last_chan) rd_addr_d = rd_addr_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            {mode_q, stride_q, new_q, padu_q, padl_q} <= '0;
            ker_q     <= '0;
            row_q     <= '0;
            trip_q    <= '0;
            limr_q    <= '0;
            limd_q    <= '0;
            kx_q      <= '0;
            ky_q      <= '0;
            pix_q     <= '0;
            chan_q    <= '0;
            rd_addr_q <= '0;
        end else if (accept) begin
            mode_q    <= conf_mode[1];
            stride_q  <= conf_stride;
            new_q     <= conf_is_new;
            padu_q    <= conf_pad_u;
            padl_q    <= conf_pad_l;
            ker_q     <= KW'(conf_ker);
            row_q     <= conf_row_cnt;
            trip_q    <= conf_trip_cnt;
            limr_q    <= conf_lim_r;
            limd_q    <= conf_lim_d;
            kx_q      <= '0;
            ky_q      <= '0;
            pix_q     <= '0;
            chan_q    <= '0;
            rd_addr_q <= '0;
        end else if (issue) begin
            kx_q      <= kx_d;
            ky_q      <= ky_d;
            pix_q     <= pix_d;
            chan_q    <= chan_d;
            rd_addr_q <= rd_addr_d;
        end
    end

    // Window and PE coordinates wrap as 8-bit two's complement; bit 7 marks a negative window.
    always_comb begin
        wx  = 8'(kx_q) - 8'(padl_q) + (stride_q ? {1'b0, pix_q, 1'b0} : {2'b00, pix_q});
        wy  = 8'(ky_q) - 8'(padu_q);
        pex = wx[0] ? wx + 8'd1 - 8'(GRP_ID_X) : wx + 8'(GRP_ID_X);
        pey = wy[0] ? wy + 8'd1 - 8'(GRP_ID_Y) : wy + 8'(GRP_ID_Y);
        lin = LIN_W'(chan_q) * LIN_W'(ker_q) * LIN_W'(ker_q)
            + LIN_W'(ky_q) * LIN_W'(ker_q) + LIN_W'(kx_q);
        tap_d = '0;
        if (issue) begin
            tap_d.valid     = 1'b1;
            tap_d.fin       = final_tap;
            tap_d.mask      = !wx[7] && (wx <= 8'(limr_q)) && !wy[7] && (wy <= 8'(limd_q));
            tap_d.mux       = {wy[0], wx[0]};
            tap_d.pe_bits   = {pey[1], pex[3:1]};
            tap_d.pbuf_addr = mode_q ? ADDR_W'({chan_q, 4'b0000} + 12'(pix_q)) : lin[LIN_W-1:SEL_W];
            tap_d.pbuf_sel  = mode_q ? '0 : lin[SEL_W-1:0];
            tap_d.abuf_addr = ADDR_W'(pix_q);
            tap_d.acc_en    = last_kx && last_ky;
            tap_d.acc_new   = last_kx && last_ky && (chan_q == 8'd0) && new_q;
            tap_d.mac_new   = (kx_q == '0) && (ky_q == '0);
        end
    end

    always_comb begin
        st1_d = pipe_q[0];
        if (pipe_q[0].valid)
            st1_d.dbuf_addr = ADDR_W'({bus.idx[IDX_W-1:0], 4'b0000} | DW'(pipe_q[0].pe_bits));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) pipe_q[i] <= '0;
        end else if (!stall) begin
            pipe_q[0] <= tap_d;
            pipe_q[1] <= st1_d;
            pipe_q[2] <= pipe_q[1];
            pipe_q[3] <= pipe_q[2];
        end
    end

    assign done             = pipe_q[3].valid && pipe_q[3].fin;
    assign bus.idx_rd_addr  = rd_addr_q;
    assign bus.out_valid    = pipe_q[3].valid;
    assign bus.dbuf_addr    = pipe_q[3].dbuf_addr;
    assign bus.dbuf_mask    = pipe_q[3].mask;
    assign bus.dbuf_mux     = pipe_q[3].mux;
    assign bus.pbuf_addr    = pipe_q[3].pbuf_addr;
    assign bus.pbuf_sel     = pipe_q[3].pbuf_sel;
    assign bus.abuf_addr    = pipe_q[3].abuf_addr;
    assign bus.abuf_acc_en  = {BATCH{pipe_q[3].acc_en}};
    assign bus.abuf_acc_new = pipe_q[3].acc_new;
    assign bus.mac_new_acc  = pipe_q[3].mac_new;

    assign unused_bits = ^{conf_mode[0], bus.idx[2*IDX_W-1:IDX_W], pex[7:4], pex[0], pey[7:2], pey[0]};
endmodule

// File: tb/tb_conv_agu_gen.sv
// Directed bench for conv_agu_gen: hand-computed tuples for CONV, padding, UCONV, stall and reset cases.
module tb_conv_agu_gen;
    localparam int ADDR_W = 8;
    localparam int IDX_W  = 4;
    localparam int BATCH  = 4;

    logic       clk = 1'b0;
    logic       rst, start, stall, busy, done;
    logic [1:0] conf_mode;
    logic [2:0] conf_ker;
    logic       conf_stride, conf_is_new, conf_pad_u, conf_pad_l;
    logic [5:0] conf_row_cnt, conf_lim_r, conf_lim_d;
    logic [7:0] conf_trip_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    int cap_cyc[$], cap_pa[$], cap_ps[$], cap_mask[$], cap_mux[$];
    int cap_db[$], cap_ab[$], cap_en[$], cap_accn[$], cap_mac[$];
    int done_cyc, busy_after_done;
    int addr_at [64];

    conv_agu_gen_if #(.ADDR_W(ADDR_W), .IDX_W(IDX_W), .BATCH(BATCH)) bus ();

    conv_agu_gen #(
        .ADDR_W(ADDR_W), .IDX_W(IDX_W), .BATCH(BATCH),
        .KER_MAX(5), .GRP_ID_Y(0), .GRP_ID_X(0)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stall(stall), .busy(busy), .done(done),
        .conf_mode(conf_mode), .conf_ker(conf_ker), .conf_stride(conf_stride),
        .conf_row_cnt(conf_row_cnt), .conf_trip_cnt(conf_trip_cnt), .conf_is_new(conf_is_new),
        .conf_pad_u(conf_pad_u), .conf_pad_l(conf_pad_l), .conf_lim_r(conf_lim_r),
        .conf_lim_d(conf_lim_d), .bus(bus)
    );

    always #5 clk = ~clk;

    // Index buffer: registered read, idx = {1, addr[3:0] + 2}.
    always @(posedge clk) bus.idx <= {4'h1, bus.idx_rd_addr[3:0] + 4'h2};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_conf(input int mode, input int ker, input int stride, input int row,
                            input int trip, input int is_new, input int pu, input int pl,
                            input int lr, input int ld);
        conf_mode     = 2'(mode);
        conf_ker      = 3'(ker);
        conf_stride   = 1'(stride);
        conf_row_cnt  = 6'(row);
        conf_trip_cnt = 8'(trip);
        conf_is_new   = 1'(is_new);
        conf_pad_u    = 1'(pu);
        conf_pad_l    = 1'(pl);
        conf_lim_r    = 6'(lr);
        conf_lim_d    = 6'(ld);
    endtask

    task automatic launch();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Records every tuple presented while not stalled; cycle 0 is the cycle after start was sampled.
    task automatic capture(input int ncyc, input int st_from, input int st_len,
                           input int busy_start_cyc, input int bs_ker);
        cap_cyc.delete(); cap_pa.delete(); cap_ps.delete(); cap_mask.delete(); cap_mux.delete();
        cap_db.delete(); cap_ab.delete(); cap_en.delete(); cap_accn.delete(); cap_mac.delete();
        done_cyc = -1;
        busy_after_done = -1;
        for (int c = 0; c < ncyc; c++) begin
            stall = (c >= st_from) && (c < st_from + st_len);
            start = (c == busy_start_cyc);
            if (c == busy_start_cyc) conf_ker = 3'(bs_ker);
            if (c < 64) addr_at[c] = int'(bus.idx_rd_addr);
            if (c > 0 && done_cyc == c - 1) busy_after_done = int'(busy);
            if (!stall && bus.out_valid) begin
                cap_cyc.push_back(c);
                cap_pa.push_back(int'(bus.pbuf_addr));
                cap_ps.push_back(int'(bus.pbuf_sel));
                cap_mask.push_back(int'(bus.dbuf_mask));
                cap_mux.push_back(int'(bus.dbuf_mux));
                cap_db.push_back(int'(bus.dbuf_addr));
                cap_ab.push_back(int'(bus.abuf_addr));
                cap_en.push_back(int'(bus.abuf_acc_en));
                cap_accn.push_back(int'(bus.abuf_acc_new));
                cap_mac.push_back(int'(bus.mac_new_acc));
            end
            if (!stall && done) done_cyc = c;
            tick();
        end
        stall = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_reset();
        set_conf(0, 3, 0, 0, 0, 1, 0, 0, 63, 63);
        rst = 1'b1;
        start = 1'b1;
        tick();
        tick();
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: busy/done/valid got %b%b%b required 000", busy, done, bus.out_valid);
        end
        n_checks++;
        if (bus.idx_rd_addr !== 8'h00 || bus.pbuf_addr !== 8'h00 || bus.dbuf_addr !== 8'h00 ||
            bus.abuf_acc_en !== 4'h0 || bus.mac_new_acc !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: rd %h pa %h da %h en %h mac %b required all 0",
                     bus.idx_rd_addr, bus.pbuf_addr, bus.dbuf_addr, bus.abuf_acc_en, bus.mac_new_acc);
        end
        rst = 1'b0;
        start = 1'b0;
        tick();
        tick();
        tick();
        n_checks++;
        if (busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_start_ignored: busy %b valid %b required 0 0", busy, bus.out_valid);
        end
    endtask

    task automatic test_conv_basic();
        int exp_db [9];
        exp_db = '{'h20, 'h21, 'h21, 'h28, 'h29, 'h29, 'h28, 'h29, 'h29};
        set_conf(0, 3, 0, 0, 0, 1, 0, 0, 63, 63);
        launch();
        capture(20, -1, 0, -1, 0);
        n_checks++;
        if (cap_pa.size() != 9) begin
            n_fail++;
            $display("FAIL basic_count: got %0d tuples required 9", cap_pa.size());
        end
        for (int i = 0; i < 9; i++) begin
            if (i < cap_pa.size()) begin
                n_checks++;
                if (cap_cyc[i] != 4 + i || cap_pa[i] != i / 4 || cap_ps[i] != i % 4) begin
                    n_fail++;
                    $display("FAIL basic_tap[%0d]: cyc %0d pa %0d ps %0d required %0d %0d %0d",
                             i, cap_cyc[i], cap_pa[i], cap_ps[i], 4 + i, i / 4, i % 4);
                end
                n_checks++;
                if (cap_accn[i] != int'(i == 8) || cap_en[i] != (i == 8 ? 15 : 0) ||
                    cap_mac[i] != int'(i == 0) || cap_mask[i] != 1 || cap_ab[i] != 0) begin
                    n_fail++;
                    $display("FAIL basic_flags[%0d]: accn %0d en %0d mac %0d mask %0d ab %0d", i,
                             cap_accn[i], cap_en[i], cap_mac[i], cap_mask[i], cap_ab[i]);
                end
                n_checks++;
                if (cap_db[i] != exp_db[i] || cap_mux[i] != (((i / 3) % 2) * 2 + (i % 3) % 2)) begin
                    n_fail++;
                    $display("FAIL basic_dbuf[%0d]: addr %h mux %0d required %h %0d", i, cap_db[i],
                             cap_mux[i], exp_db[i], ((i / 3) % 2) * 2 + (i % 3) % 2);
                end
            end
        end
        n_checks++;
        if (done_cyc != 12 || busy_after_done != 0) begin
            n_fail++;
            $display("FAIL basic_done: done cyc %0d busy after %0d required 12 0", done_cyc, busy_after_done);
        end
    endtask

    task automatic test_padding();
        int ones;
        set_conf(0, 3, 0, 0, 0, 1, 1, 1, 1, 1);
        launch();
        capture(20, -1, 0, -1, 0);
        ones = 0;
        n_checks++;
        if (cap_mask.size() != 9) begin
            n_fail++;
            $display("FAIL pad_count: got %0d tuples required 9", cap_mask.size());
        end
        for (int i = 0; i < 9; i++) begin
            if (i < cap_mask.size()) begin
                ones += cap_mask[i];
                n_checks++;
                if (cap_mask[i] != int'((i % 3) != 0 && (i / 3) != 0)) begin
                    n_fail++;
                    $display("FAIL pad_mask[%0d]: got %0d required %0d", i, cap_mask[i],
                             int'((i % 3) != 0 && (i / 3) != 0));
                end
            end
        end
        n_checks++;
        if (ones != 4) begin
            n_fail++;
            $display("FAIL pad_ones: got %0d in-bounds taps required 4", ones);
        end
        if (cap_mux.size() == 9) begin
            n_checks++;
            if (cap_mux[0] != 3 || cap_mux[4] != 0 || cap_mux[8] != 3) begin
                n_fail++;
                $display("FAIL pad_mux: got %0d %0d %0d required 3 0 3", cap_mux[0], cap_mux[4], cap_mux[8]);
            end
            n_checks++;
            if (cap_db[0] != 'h20 || cap_db[4] != 'h20 || cap_db[8] != 'h29) begin
                n_fail++;
                $display("FAIL pad_dbuf: got %h %h %h required 20 20 29", cap_db[0], cap_db[4], cap_db[8]);
            end
        end
    endtask

    task automatic test_uconv();
        int exp_pa [8];
        int exp_db [8];
        exp_pa = '{0, 1, 2, 3, 16, 17, 18, 19};
        exp_db = '{'h20, 'h21, 'h22, 'h23, 'h30, 'h31, 'h32, 'h33};
        set_conf(2, 1, 1, 3, 1, 1, 0, 0, 63, 63);
        launch();
        capture(20, -1, 0, -1, 0);
        n_checks++;
        if (cap_pa.size() != 8) begin
            n_fail++;
            $display("FAIL uconv_count: got %0d tuples required 8", cap_pa.size());
        end
        for (int i = 0; i < 8; i++) begin
            if (i < cap_pa.size()) begin
                n_checks++;
                if (cap_pa[i] != exp_pa[i] || cap_ps[i] != 0 || cap_ab[i] != i % 4) begin
                    n_fail++;
                    $display("FAIL uconv_addr[%0d]: pa %0d ps %0d ab %0d required %0d 0 %0d",
                             i, cap_pa[i], cap_ps[i], cap_ab[i], exp_pa[i], i % 4);
                end
                n_checks++;
                if (cap_en[i] != 15 || cap_accn[i] != int'(i < 4) || cap_mac[i] != 1 || cap_mux[i] != 0) begin
                    n_fail++;
                    $display("FAIL uconv_flags[%0d]: en %0d accn %0d mac %0d mux %0d", i,
                             cap_en[i], cap_accn[i], cap_mac[i], cap_mux[i]);
                end
                n_checks++;
                if (cap_db[i] != exp_db[i]) begin
                    n_fail++;
                    $display("FAIL uconv_dbuf[%0d]: got %h required %h", i, cap_db[i], exp_db[i]);
                end
            end
        end
        n_checks++;
        if (addr_at[0] != 0 || addr_at[3] != 0 || addr_at[4] != 1) begin
            n_fail++;
            $display("FAIL uconv_idx_rd_addr: got %0d %0d %0d required 0 0 1", addr_at[0], addr_at[3], addr_at[4]);
        end
        n_checks++;
        if (done_cyc != 11) begin
            n_fail++;
            $display("FAIL uconv_done: got cycle %0d required 11", done_cyc);
        end
    endtask

    task automatic test_stall();
        set_conf(0, 3, 0, 0, 0, 1, 0, 0, 63, 63);
        launch();
        capture(24, 5, 3, -1, 0);
        n_checks++;
        if (cap_pa.size() != 9) begin
            n_fail++;
            $display("FAIL stall_count: got %0d tuples required 9", cap_pa.size());
        end
        for (int i = 0; i < 9; i++) begin
            if (i < cap_pa.size()) begin
                n_checks++;
                if (cap_cyc[i] != (i == 0 ? 4 : 7 + i) || cap_pa[i] != i / 4 || cap_ps[i] != i % 4) begin
                    n_fail++;
                    $display("FAIL stall_tap[%0d]: cyc %0d pa %0d ps %0d required %0d %0d %0d",
                             i, cap_cyc[i], cap_pa[i], cap_ps[i], (i == 0 ? 4 : 7 + i), i / 4, i % 4);
                end
            end
        end
        n_checks++;
        if (done_cyc != 15) begin
            n_fail++;
            $display("FAIL stall_done: got cycle %0d required 15", done_cyc);
        end
    endtask

    task automatic test_back_to_back();
        set_conf(0, 3, 0, 0, 0, 1, 0, 0, 63, 63);
        launch();
        capture(14, -1, 0, 3, 1);
        n_checks++;
        if (cap_pa.size() != 9 || done_cyc != 12 || busy_after_done != 0) begin
            n_fail++;
            $display("FAIL busy_start: tuples %0d done %0d busy after %0d required 9 12 0",
                     cap_pa.size(), done_cyc, busy_after_done);
        end
        if (cap_pa.size() == 9) begin
            n_checks++;
            if (cap_pa[8] != 2 || cap_ps[8] != 0 || cap_pa[5] != 1 || cap_ps[5] != 1) begin
                n_fail++;
                $display("FAIL busy_start_pbuf: tap5 %0d/%0d tap8 %0d/%0d required 1/1 2/0",
                         cap_pa[5], cap_ps[5], cap_pa[8], cap_ps[8]);
            end
        end
        set_conf(2, 1, 1, 3, 1, 1, 0, 0, 63, 63);
        launch();
        capture(16, -1, 0, -1, 0);
        n_checks++;
        if (cap_pa.size() != 8 || done_cyc != 11 || cap_cyc.size() == 0 || cap_cyc[0] != 4) begin
            n_fail++;
            $display("FAIL b2b_second_job: tuples %0d done %0d required 8 11", cap_pa.size(), done_cyc);
        end
        if (cap_pa.size() == 8) begin
            n_checks++;
            if (cap_pa[4] != 16 || cap_pa[7] != 19) begin
                n_fail++;
                $display("FAIL b2b_pbuf: got %0d %0d required 16 19", cap_pa[4], cap_pa[7]);
            end
        end
    endtask

    task automatic test_reset_midjob();
        set_conf(0, 3, 0, 0, 0, 1, 0, 0, 63, 63);
        launch();
        capture(6, -1, 0, -1, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || bus.out_valid !== 1'b0 || done !== 1'b0 || bus.pbuf_addr !== 8'h00 ||
            bus.dbuf_addr !== 8'h00 || bus.idx_rd_addr !== 8'h00 || bus.abuf_acc_en !== 4'h0) begin
            n_fail++;
            $display("FAIL midjob_reset: busy %b valid %b done %b pa %h da %h rd %h required all 0",
                     busy, bus.out_valid, done, bus.pbuf_addr, bus.dbuf_addr, bus.idx_rd_addr);
        end
        tick();
        tick();
        n_checks++;
        if (busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midjob_idle: busy %b valid %b required 0 0", busy, bus.out_valid);
        end
        launch();
        capture(20, -1, 0, -1, 0);
        n_checks++;
        if (cap_pa.size() != 9 || done_cyc != 12) begin
            n_fail++;
            $display("FAIL midjob_rerun: tuples %0d done %0d required 9 12", cap_pa.size(), done_cyc);
        end
        for (int i = 0; i < 9; i++) begin
            if (i < cap_pa.size()) begin
                n_checks++;
                if (cap_cyc[i] != 4 + i || cap_pa[i] != i / 4 || cap_ps[i] != i % 4 ||
                    cap_accn[i] != int'(i == 8)) begin
                    n_fail++;
                    $display("FAIL midjob_tap[%0d]: cyc %0d pa %0d ps %0d accn %0d", i,
                             cap_cyc[i], cap_pa[i], cap_ps[i], cap_accn[i]);
                end
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        stall = 1'b0;
        set_conf(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_conv_basic();
        test_padding();
        test_uconv();
        test_stall();
        test_back_to_back();
        test_reset_midjob();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/conv_agu_gen.md
CONV_AGU_GEN -- requirements
Module: conv_agu_gen

Interface
REQ-001 SHALL have parameters (name, default, meaning): ADDR_W, 8, buffer address width; IDX_W, 4, index field width; BATCH, 4, batch lanes, power of 2, at least 2; KER_MAX, 5, largest kernel side; GRP_ID_Y, 0, PE group row; GRP_ID_X, 0, PE group column.
REQ-002 SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, single clock.
- rst, in, 1, synchronous active-high reset.
- start, in, 1, pulse that begins a job.
- stall, in, 1, freezes counters and pipeline.
- busy, out, 1, job in progress.
- done, out, 1, one-cycle completion pulse.
- conf_mode, in, 2, bit1=1 selects UCONV, otherwise CONV.
- conf_ker, in, 3, kernel side K, 1..KER_MAX.
- conf_stride, in, 1, 0 gives stride 1, 1 gives stride 2.
- conf_row_cnt, in, 6, last pixel index in a row.
- conf_trip_cnt, in, 8, last channel index.
- conf_is_new, in, 1, start a fresh accumulation.
- conf_pad_u, in, 1, top padding.
- conf_pad_l, in, 1, left padding.
- conf_lim_r, in, 6, last valid window x.
- conf_lim_d, in, 6, last valid window y.
- idx_rd_addr, out, ADDR_W, index buffer read address.
- idx, in, 2*IDX_W, {idx_y, idx_x}.
- out_valid, out, 1, output tuple valid.
- dbuf_addr, out, ADDR_W, data buffer address.
- dbuf_mask, out, 1, 1 means in-bounds (not padding).
- dbuf_mux, out, 2, data-sharing select.
- pbuf_addr, out, ADDR_W, parameter buffer address.
- pbuf_sel, out, log2(BATCH), parameter scalar select.
- abuf_addr, out, ADDR_W, accumulate buffer address.
- abuf_acc_en, out, BATCH, accumulate lane enable.
- abuf_acc_new, out, 1, overwrite instead of add.
- mac_new_acc, out, 1, MAC clears its accumulator.

Function
REQ-003 SHALL implement a 3-state FSM:
- IDLE goes to RUN on start.
- RUN goes to DRAIN after issuing the final tap.
- DRAIN goes to IDLE once the final tuple has left the pipeline.
- busy SHALL be 1 in RUN and DRAIN.
REQ-004 SHALL latch all conf_* inputs on an accepted start. start SHALL be ignored while busy.
REQ-005 SHALL use nested counters, innermost first. Each wraps to 0 and carries into the next.
- ker_x: 0..K-1.
- ker_y: 0..K-1.
- pix: 0..conf_row_cnt.
- chan: 0..conf_trip_cnt.
REQ-006 In RUN with stall=0, the block SHALL issue one tap per cycle and advance the counters once.
REQ-007 SHALL make the final tap the one where every counter is at its maximum. K=1 and conf_row_cnt=0 are legal.
REQ-008 Index read address:
- idx_rd_addr SHALL be 0 after start.
- It SHALL increment when chan advances.
- It SHALL wrap modulo 2^ADDR_W.
REQ-009 Window coordinates, computed as signed 8-bit values:
- win_y = ker_y - pad_u.
- win_x = ker_x - pad_l + pix*(stride+1).
REQ-010 dbuf_mask SHALL be 1 iff 0 <= win_x <= lim_r and 0 <= win_y <= lim_d.
REQ-011 dbuf_mux SHALL be {win_y[0], win_x[0]}.
REQ-012 PE coordinates: for each axis, pe = (w odd) ? w+1-GRP_ID : w+GRP_ID.
REQ-013 dbuf_addr SHALL be idx_x zero-extended and shifted left 4, OR'ed with {pe_y[1], pe_x[3:1]}, then truncated to ADDR_W.
REQ-014 In CONV mode:
- lin = chan*K*K + ker_y*K + ker_x, computed as an unsigned value at least ADDR_W + log2(BATCH) wide.
- pbuf_addr = lin >> log2(BATCH).
- pbuf_sel = low log2(BATCH) bits of lin.
REQ-015 In UCONV mode:
- pbuf_addr = (chan << 4) + pix, truncated to ADDR_W.
- pbuf_sel = 0.
REQ-016 abuf_addr SHALL equal pix, zero-extended.
REQ-017 mac_new_acc SHALL be 1 on the first tap (ker_x=0, ker_y=0) of every pixel.
REQ-018 abuf_acc_new SHALL be 1 on the last tap of each pixel when chan=0 and conf_is_new=1.
REQ-019 abuf_acc_en SHALL be all ones on the last tap of each pixel and 0 otherwise.
REQ-020 Every output field of a tap SHALL appear on the same cycle, with out_valid=1.
- Latency is exactly 4 unstalled cycles after the tap is issued.
- idx is sampled 2 cycles after idx_rd_addr changes.
REQ-021 stall=1 SHALL hold all state, including pipeline registers and outputs, unchanged.
REQ-022 done SHALL pulse for 1 cycle, coincident with out_valid of the final tap. The FSM SHALL enter IDLE on the next cycle.
REQ-023 When out_valid=0, every output except busy and idx_rd_addr SHALL be 0.

Reset
REQ-024 rst SHALL force IDLE and clear all counters and pipeline registers at any time, including mid-job.
REQ-025 While rst is asserted, and after reset until the next start, all outputs SHALL be 0.
REQ-026 A start asserted in the same cycle as rst SHALL be ignored.

Verification
REQ-027 K=3, row_cnt=0, trip_cnt=0, no pad, conf_is_new=1, CONV mode -> 9 valid tuples beginning 4 cycles after start; pbuf_addr/pbuf_sel run 0/0..2/0; done coincides with the 9th tuple; abuf_acc_new=1 only on the 9th.
REQ-028 K=3, pad_u=1, pad_l=1, lim_r=lim_d=1 -> dbuf_mask is 0 on every tap with ker_x=0 or ker_y=0, i.e. 5 of 9 taps.
REQ-029 K=1, stride=2, row_cnt=3, trip_cnt=1, UCONV mode -> 8 tuples; pbuf_addr = 0,1,2,3,16,17,18,19; idx_rd_addr = 1 after the 4th tap is issued.
REQ-030 stall held high for 3 cycles mid-job -> output sequence identical to the unstalled run, shifted by 3 cycles, with no duplicated or dropped tuple.
REQ-031 rst pulsed mid-job, then a new start -> busy=0 and outputs 0 the cycle after reset; the second job's output matches a fresh run; start during busy is ignored.
